// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings and small decode helpers for the 3-master arbiter.
package ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HBURST_SINGLE = 3'b000,
    HBURST_INCR   = 3'b001,
    HBURST_WRAP4  = 3'b010,
    HBURST_INCR4  = 3'b011,
    HBURST_WRAP8  = 3'b100,
    HBURST_INCR8  = 3'b101,
    HBURST_WRAP16 = 3'b110,
    HBURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01,
    HRESP_RETRY = 2'b10,
    HRESP_SPLIT = 2'b11
  } hresp_e;

  // Beats in a fixed-length burst; undefined-length bursts report zero.
  function automatic logic [4:0] burst_len(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_len = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_len = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_len = 5'd16;
      default:                      burst_len = 5'd0;
    endcase
  endfunction

  // Index of a one-hot 3-bit grant; anything unexpected maps to master 0.
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    case (oh)
      3'b010:  onehot_idx = 2'd1;
      3'b100:  onehot_idx = 2'd2;
      default: onehot_idx = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_prio_enc3.sv
// Fixed-priority one-hot select over three requesters; bit 0 has top priority.
module ahb_arbiter_prio_enc3 (
  input  logic [2:0] req,
  output logic [2:0] gnt
);

  // Lowest set request bit wins; no request gives an all-zero result.
  always_comb begin
    gnt = 3'b000;
    if (req[0]) begin
      gnt = 3'b001;
    end else if (req[1]) begin
      gnt = 3'b010;
    end else if (req[2]) begin
      gnt = 3'b100;
    end else begin
      gnt = 3'b000;
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB arbiter for three fixed-priority masters with lock, burst-boundary
// re-arbitration and RETRY/SPLIT handling. All outputs are registered.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
(
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  HBUSREQ,
  input  logic [2:0]  HLOCK,
  input  logic [31:0] HADDR,
  input  logic [2:0]  HSPLIT,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [1:0]  HRESP,
  input  logic        HREADY,
  output logic [1:0]  HMASTER,
  output logic        HMASTLOCK,
  output logic [2:0]  HGRANT
);

  logic [2:0] hgrant_r, pend_r, lockreq_r, splitmask_r;
  logic [1:0] hmaster_r;
  logic       hmastlock_r;
  logic [4:0] beatcnt_r;

  logic [2:0] splitset_s, retryset_s, elig_s, win_s;
  logic [2:0] grant_nxt_s, pend_nxt_s, lockreq_nxt_s, mask_nxt_s;
  logic [4:0] beatcnt_nxt_s;
  logic [1:0] owner_s;
  logic       owner_req_s, owner_lock_s, fixed_s, lock_hold_s, arb_s;

  // HADDR is reserved and deliberately not used by the arbiter.
  logic unused_haddr_s;
  assign unused_haddr_s = ^HADDR;

  ahb_arbiter_prio_enc3 u_prio (
    .req (elig_s),
    .gnt (win_s)
  );

  // Arbitration decision and next-state values for all arbiter state.
  always_comb begin
    owner_s      = onehot_idx(hgrant_r);
    owner_req_s  = |((HBUSREQ | pend_r) & hgrant_r);
    owner_lock_s = |(lockreq_r & hgrant_r);
    fixed_s      = !((HBURST == HBURST_SINGLE) || (HBURST == HBURST_INCR));

    // RETRY/SPLIT only act on their second (HREADY high) cycle.
    if (HREADY && (HRESP == HRESP_SPLIT)) begin
      splitset_s = 3'b001 << hmaster_r;
    end else begin
      splitset_s = 3'b000;
    end
    if (HREADY && (HRESP == HRESP_RETRY)) begin
      retryset_s = 3'b001 << hmaster_r;
    end else begin
      retryset_s = 3'b000;
    end

    // A master being split this edge is already excluded from the contest.
    elig_s = (pend_r | HBUSREQ) & ~(splitmask_r | splitset_s);

    // A locked owner keeps the bus until its lock request drops on an IDLE cycle.
    lock_hold_s = hmastlock_r && !(!owner_lock_s && (HTRANS == HTRANS_IDLE));

    arb_s = HREADY &&
            ((!lock_hold_s && ((HTRANS == HTRANS_IDLE) ||
                               (!fixed_s && !owner_req_s) ||
                               (fixed_s && (beatcnt_r == 5'd1)))) ||
             (HRESP == HRESP_RETRY) || (HRESP == HRESP_SPLIT));

    // Empty eligible set parks the bus on the last owner.
    if (arb_s && (win_s != 3'b000)) begin
      grant_nxt_s = win_s;
      pend_nxt_s  = (pend_r | HBUSREQ | retryset_s | splitset_s) & ~win_s;
    end else begin
      grant_nxt_s = hgrant_r;
      pend_nxt_s  = pend_r | HBUSREQ | retryset_s | splitset_s;
    end

    // The granted master's lock request follows HLOCK live so it can release;
    // other masters keep a latched copy until they win.
    lockreq_nxt_s = (HLOCK & hgrant_r) | ((lockreq_r | HLOCK) & ~hgrant_r);

    // Split resume beats a same-edge split set.
    mask_nxt_s = (splitmask_r | splitset_s) & ~HSPLIT;

    if (HREADY && (HTRANS == HTRANS_NONSEQ)) begin
      beatcnt_nxt_s = burst_len(HBURST);
    end else if (HREADY && (HTRANS == HTRANS_SEQ) && (beatcnt_r != 5'd0)) begin
      beatcnt_nxt_s = beatcnt_r - 5'd1;
    end else begin
      beatcnt_nxt_s = beatcnt_r;
    end
  end

  // State update with synchronous reset; address-phase outputs follow the grant when HREADY.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hgrant_r    <= 3'b001;
      hmaster_r   <= 2'd0;
      hmastlock_r <= 1'b0;
      pend_r      <= 3'b000;
      lockreq_r   <= 3'b000;
      splitmask_r <= 3'b000;
      beatcnt_r   <= 5'd0;
    end else begin
      hgrant_r    <= grant_nxt_s;
      pend_r      <= pend_nxt_s;
      lockreq_r   <= lockreq_nxt_s;
      splitmask_r <= mask_nxt_s;
      beatcnt_r   <= beatcnt_nxt_s;
      if (HREADY) begin
        hmaster_r   <= owner_s;
        hmastlock_r <= owner_lock_s;
      end else begin
        hmaster_r   <= hmaster_r;
        hmastlock_r <= hmastlock_r;
      end
    end
  end

  assign HGRANT    = hgrant_r;
  assign HMASTER   = hmaster_r;
  assign HMASTLOCK = hmastlock_r;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: each step drives one cycle of bus inputs,
// queues the hand-derived outputs expected after that edge, then checks them.
module tb_ahb_arbiter;
  import ahb_arbiter_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [2:0]  HBUSREQ, HLOCK, HSPLIT, HBURST, HGRANT;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS, HRESP, HMASTER;
  logic        HREADY, HMASTLOCK;

  localparam logic [1:0] ID  = 2'b00;
  localparam logic [1:0] NS  = 2'b10;
  localparam logic [1:0] SQ  = 2'b11;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] RT  = 2'b10;
  localparam logic [1:0] SP  = 2'b11;
  localparam logic [2:0] SNG = 3'b000;
  localparam logic [2:0] I4  = 3'b011;
  localparam logic [2:0] I8  = 3'b101;

  typedef struct packed {
    logic [2:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  ahb_arbiter dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HBUSREQ   (HBUSREQ),
    .HLOCK     (HLOCK),
    .HADDR     (HADDR),
    .HSPLIT    (HSPLIT),
    .HTRANS    (HTRANS),
    .HBURST    (HBURST),
    .HRESP     (HRESP),
    .HREADY    (HREADY),
    .HMASTER   (HMASTER),
    .HMASTLOCK (HMASTLOCK),
    .HGRANT    (HGRANT)
  );

  always #5 HCLK = ~HCLK;

  task automatic step(input string tag, input logic rstn, input logic [2:0] req,
                      input logic [2:0] lock, input logic [2:0] split,
                      input logic [1:0] trans, input logic [2:0] burst,
                      input logic [1:0] resp, input logic rdy,
                      input logic [2:0] eg, input logic [1:0] em, input logic el);
    exp_t e;
    HRESETn = rstn;
    HBUSREQ = req;
    HLOCK   = lock;
    HSPLIT  = split;
    HTRANS  = trans;
    HBURST  = burst;
    HRESP   = resp;
    HREADY  = rdy;
    HADDR   = $urandom();
    e.g = eg;
    e.m = em;
    e.l = el;
    exp_q.push_back(e);
    @(posedge HCLK);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (HGRANT === e.g) else begin
      failures++;
      $error("FAIL %s hgrant got=%b exp=%b", tag, HGRANT, e.g);
    end
    checks++;
    assert (HMASTER === e.m) else begin
      failures++;
      $error("FAIL %s hmaster got=%0d exp=%0d", tag, HMASTER, e.m);
    end
    checks++;
    assert (HMASTLOCK === e.l) else begin
      failures++;
      $error("FAIL %s hmastlock got=%b exp=%b", tag, HMASTLOCK, e.l);
    end
  endtask

  initial begin
    //        tag           rst req     lock    split   trn bst  rsp rdy  grant   mst   lck
    step("rst0",       1'b0, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b001, 2'd0, 1'b0);
    step("rst1",       1'b0, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b001, 2'd0, 1'b0);
    // Locked request from master 1 on an idle bus.
    step("t1_req",     1'b1, 3'b010, 3'b010, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd0, 1'b0);
    step("t1_own",     1'b1, 3'b000, 3'b010, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd1, 1'b1);
    // Locked INCR4 holds the bus against higher and lower priority requests.
    step("t2_ns",      1'b1, 3'b010, 3'b010, 3'b000, NS, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t2_sq1",     1'b1, 3'b001, 3'b010, 3'b000, SQ, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t2_sq2",     1'b1, 3'b110, 3'b010, 3'b000, SQ, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t2_sq3",     1'b1, 3'b000, 3'b010, 3'b000, SQ, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t2_unlock",  1'b1, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t2_rearb",   1'b1, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b001, 2'd1, 1'b0);
    step("t2_pend1",   1'b1, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd0, 1'b0);
    step("t2_pend2",   1'b1, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b100, 2'd1, 1'b0);
    // Master 2 INCR4 with a two-cycle RETRY.
    step("t3_own",     1'b1, 3'b100, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t3_ns",      1'b1, 3'b100, 3'b000, 3'b000, NS, I4,  OK, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t3_sq",      1'b1, 3'b100, 3'b000, 3'b000, SQ, I4,  OK, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t3_rty_wait",1'b1, 3'b100, 3'b000, 3'b000, SQ, I4,  RT, 1'b0, 3'b100, 2'd2, 1'b0);
    step("t3_rty",     1'b1, 3'b100, 3'b000, 3'b000, SQ, I4,  RT, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t3_restart", 1'b1, 3'b100, 3'b000, 3'b000, NS, I4,  OK, 1'b1, 3'b100, 2'd2, 1'b0);
    // Master 1 gets SPLIT while master 2 requests.
    step("t4_req1",    1'b1, 3'b010, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd2, 1'b0);
    step("t4_ns",      1'b1, 3'b110, 3'b000, 3'b000, NS, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b0);
    step("t4_spl_wait",1'b1, 3'b110, 3'b000, 3'b000, SQ, I4,  SP, 1'b0, 3'b010, 2'd1, 1'b0);
    step("t4_spl",     1'b1, 3'b110, 3'b000, 3'b000, ID, SNG, SP, 1'b1, 3'b100, 2'd1, 1'b0);
    step("t4_masked",  1'b1, 3'b010, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b100, 2'd2, 1'b0);
    // Master 2 INCR8; master 0 waits for the last-beat edge.
    step("t5_ns",      1'b1, 3'b100, 3'b000, 3'b001, NS, I8,  OK, 1'b1, 3'b100, 2'd2, 1'b0);
    step("t5_sq_req0", 1'b1, 3'b101, 3'b000, 3'b000, SQ, I8,  OK, 1'b1, 3'b100, 2'd2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step("t5_sq_hold", 1'b1, 3'b100, 3'b000, 3'b000, SQ, I8, OK, 1'b1, 3'b100, 2'd2, 1'b0);
    end
    step("t5_last",    1'b1, 3'b100, 3'b000, 3'b000, NS, I8,  OK, 1'b1, 3'b001, 2'd2, 1'b0);
    step("t5_unsplit", 1'b1, 3'b000, 3'b000, 3'b010, ID, SNG, OK, 1'b1, 3'b100, 2'd0, 1'b0);
    step("t5_m1_back", 1'b1, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd2, 1'b0);
    // Reset in the middle of a locked, split burst.
    step("t6_ns",      1'b1, 3'b010, 3'b010, 3'b000, NS, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b0);
    step("t6_sq",      1'b1, 3'b010, 3'b010, 3'b000, SQ, I4,  OK, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t6_spl",     1'b1, 3'b010, 3'b010, 3'b000, SQ, I4,  SP, 1'b1, 3'b010, 2'd1, 1'b1);
    step("t6_rst",     1'b0, 3'b010, 3'b010, 3'b000, SQ, I4,  OK, 1'b1, 3'b001, 2'd0, 1'b0);
    step("t6_req1",    1'b1, 3'b010, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd0, 1'b0);
    step("t6_park",    1'b1, 3'b000, 3'b000, 3'b000, ID, SNG, OK, 1'b1, 3'b010, 2'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
